gx4000_sprite_mixer: RTL and testbench

GX4000_SPRITE_MIXER -- requirements
Module: gx4000_sprite_mixer

---
 rtl/gx4000_pkg.sv | 17 +
 rtl/gx4000_sprite_palette.sv | 31 +++
 rtl/gx4000_sprite_mixer.sv | 127 ++++++++++++
 tb/tb_gx4000_sprite_mixer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gx4000_pkg.sv
// Shared types and constants for the GX4000 video path.
package gx4000_pkg;

  typedef logic [11:0] rgb12_t;

  localparam int SPR_PAL_DEPTH = 16;
  localparam int SPR_PAL_AW    = $clog2(SPR_PAL_DEPTH);
  localparam int MIX_LATENCY   = 2;
  localparam int SPR_COUNT     = 8;

  // Index 0 is transparent, and so is any pixel from an absent sprite slot.
  function automatic logic spr_opaque(input logic active, input logic [3:0] id,
                                      input logic [3:0] idx);
    return active && !id[3] && (idx != 4'd0);
  endfunction

endpackage

// File: rtl/gx4000_sprite_palette.sv
// 16x12 sprite palette: one write port, one registered read port.
// A read of the address being written in the same cycle returns the new data.
module gx4000_sprite_palette
  import gx4000_pkg::*;
(
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [SPR_PAL_AW-1:0] i_waddr,
  input  logic [11:0]           i_wdata,
  input  logic                  i_rd_en,
  input  logic [SPR_PAL_AW-1:0] i_raddr,
  output logic [11:0]           o_rdata
);

  rgb12_t r_mem [SPR_PAL_DEPTH];
  rgb12_t r_rdata;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < SPR_PAL_DEPTH; i++) r_mem[i] <= '0;
      r_rdata <= '0;
    end else begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_rd_en) r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/gx4000_sprite_mixer.sv
// Two-stage sprite/playfield mixer with per-sprite collision latching.
// Stage 1 registers the pixel and reads the palette; stage 2 selects the colour.
module gx4000_sprite_mixer
  import gx4000_pkg::*;
(
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ce_pix,
  input  logic                 hblank,
  input  logic                 vblank,
  input  logic                 border,
  input  logic [11:0]          pf_rgb,
  input  logic [3:0]           pf_pen,
  input  logic [7:0]           spr_pixel,
  input  logic                 spr_active,
  input  logic [3:0]           spr_id,
  input  logic [11:0]          border_rgb,
  input  logic [7:0]           prio_mask,
  input  logic                 coll_en,
  input  logic                 pal_we,
  input  logic [3:0]           pal_addr,
  input  logic [11:0]          pal_data,
  input  logic                 coll_rd,
  output logic [11:0]          rgb_out,
  output logic                 hb_out,
  output logic                 vb_out,
  output logic [SPR_COUNT-1:0] coll_flags,
  output logic                 coll_irq
);

  function automatic rgb12_t mix_pixel(input logic blank, input logic bord,
                                       input rgb12_t bcol, input logic show_spr,
                                       input rgb12_t spr_col, input rgb12_t pf_col);
    if (blank)    return '0;
    if (bord)     return bcol;
    if (show_spr) return spr_col;
    return pf_col;
  endfunction

  rgb12_t               w_pal_rgb_p1;
  logic                 r_hb_p1, r_vb_p1, r_border_p1, r_opaque_p1, r_behind_p1, r_coll_en_p1;
  logic [3:0]           r_pf_pen_p1;
  logic [2:0]           r_sid_p1;
  rgb12_t               r_pf_rgb_p1, r_bcol_p1;
  rgb12_t               r_rgb_p2;
  logic                 r_hb_p2, r_vb_p2;
  logic [SPR_COUNT-1:0] r_coll_flags, w_hit_vec, w_flags_nxt;
  logic                 r_coll_irq;
  logic                 w_blank_p1, w_show_spr_p1, w_hit_p1;
  logic                 w_unused;

  assign w_unused = ^spr_pixel[7:4];

  gx4000_sprite_palette u_palette (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_we    (pal_we),
    .i_waddr (pal_addr),
    .i_wdata (pal_data),
    .i_rd_en (ce_pix),
    .i_raddr (spr_pixel[3:0]),
    .o_rdata (w_pal_rgb_p1)
  );

  // Stage 1: register the pixel; blanking flags flush to blanked on reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_hb_p1 <= 1'b1;
      r_vb_p1 <= 1'b1;
    end else if (ce_pix) begin
      r_hb_p1 <= hblank;
      r_vb_p1 <= vblank;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (ce_pix) begin
      r_border_p1  <= border;
      r_pf_rgb_p1  <= pf_rgb;
      r_pf_pen_p1  <= pf_pen;
      r_opaque_p1  <= spr_opaque(spr_active, spr_id, spr_pixel[3:0]);
      r_sid_p1     <= spr_id[2:0];
      r_behind_p1  <= prio_mask[spr_id[2:0]];
      r_bcol_p1    <= border_rgb;
      r_coll_en_p1 <= coll_en;
    end
  end

  // Stage 2: colour selection and collision detection.
  assign w_blank_p1    = r_hb_p1 | r_vb_p1;
  assign w_show_spr_p1 = r_opaque_p1 && (!r_behind_p1 || (r_pf_pen_p1 == 4'd0));
  assign w_hit_p1      = r_coll_en_p1 && !w_blank_p1 && !r_border_p1 && r_opaque_p1 &&
                         (r_pf_pen_p1 != 4'd0);
  assign w_hit_vec     = (ce_pix && w_hit_p1) ? (SPR_COUNT'(1) << r_sid_p1) : '0;
  assign w_flags_nxt   = (coll_rd ? '0 : r_coll_flags) | w_hit_vec;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_rgb_p2 <= '0;
      r_hb_p2  <= 1'b1;
      r_vb_p2  <= 1'b1;
    end else if (ce_pix) begin
      r_rgb_p2 <= mix_pixel(w_blank_p1, r_border_p1, r_bcol_p1, w_show_spr_p1,
                            w_pal_rgb_p1, r_pf_rgb_p1);
      r_hb_p2  <= r_hb_p1;
      r_vb_p2  <= r_vb_p1;
    end
  end

  // A read clear and a simultaneous hit resolve in favour of the hit.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_coll_flags <= '0;
      r_coll_irq   <= 1'b0;
    end else begin
      r_coll_flags <= w_flags_nxt;
      r_coll_irq   <= (r_coll_flags == '0) && (w_flags_nxt != '0);
    end
  end

  assign rgb_out    = r_rgb_p2;
  assign hb_out     = r_hb_p2;
  assign vb_out     = r_vb_p2;
  assign coll_flags = r_coll_flags;
  assign coll_irq   = r_coll_irq;

endmodule

// File: tb/tb_gx4000_sprite_mixer.sv
// Self-checking bench for gx4000_sprite_mixer: reference model plus directed checks.
module tb_gx4000_sprite_mixer;
  import gx4000_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset, ce_pix, hblank, vblank, border, spr_active, coll_en, pal_we, coll_rd;
  logic [11:0] pf_rgb, border_rgb, pal_data, rgb_out;
  logic [3:0]  pf_pen, spr_id, pal_addr;
  logic [7:0]  spr_pixel, prio_mask, coll_flags;
  logic        hb_out, vb_out, coll_irq;

  initial forever #5 clk_sys = ~clk_sys;

  gx4000_sprite_mixer dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .hblank(hblank), .vblank(vblank),
    .border(border), .pf_rgb(pf_rgb), .pf_pen(pf_pen), .spr_pixel(spr_pixel),
    .spr_active(spr_active), .spr_id(spr_id), .border_rgb(border_rgb), .prio_mask(prio_mask),
    .coll_en(coll_en), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .coll_rd(coll_rd), .rgb_out(rgb_out), .hb_out(hb_out), .vb_out(vb_out),
    .coll_flags(coll_flags), .coll_irq(coll_irq)
  );

  // One pixel as seen by the mixer, with its palette colour already resolved.
  typedef struct {
    logic hb, vb, bord, opq, behind, cen;
    logic [11:0] pf_rgb, pal_col, bcol;
    logic [3:0]  pf_pen;
    logic [2:0]  sid;
  } samp_t;

  samp_t       q[$];
  logic [11:0] m_pal [16];
  logic [11:0] m_rgb;
  logic        m_hb, m_vb, m_irq;
  logic [7:0]  m_flags;
  int          vectors = 0;
  int          miscompares = 0;
  bit          chk_on = 0;

  function automatic logic [11:0] exp_mix(input samp_t s);
    if (s.hb || s.vb) return 12'h000;
    if (s.bord) return s.bcol;
    if (s.opq && (!s.behind || s.pf_pen == 4'd0)) return s.pal_col;
    return s.pf_rgb;
  endfunction

  // Reference model: a delay line of pixels, palette array and collision set.
  initial begin
    samp_t s, ns, blank;
    logic [7:0] hit, nf;
    blank = '{hb:1'b1, vb:1'b1, bord:1'b0, opq:1'b0, behind:1'b0, cen:1'b0,
              pf_rgb:12'h0, pal_col:12'h0, bcol:12'h0, pf_pen:4'h0, sid:3'h0};
    forever begin
      @(posedge clk_sys);
      if (reset) begin
        for (int i = 0; i < 16; i++) m_pal[i] = 12'h000;
        q.delete();
        for (int i = 1; i < MIX_LATENCY; i++) q.push_back(blank);
        m_rgb = 12'h000; m_hb = 1'b1; m_vb = 1'b1; m_flags = 8'h00; m_irq = 1'b0;
      end else begin
        hit = 8'h00;
        if (ce_pix) begin
          ns.hb = hblank; ns.vb = vblank; ns.bord = border; ns.cen = coll_en;
          ns.opq = spr_active && !spr_id[3] && (spr_pixel[3:0] != 4'd0);
          ns.sid = spr_id[2:0];
          ns.behind = prio_mask[spr_id[2:0]];
          ns.pal_col = (pal_we && pal_addr == spr_pixel[3:0]) ? pal_data : m_pal[spr_pixel[3:0]];
          ns.pf_rgb = pf_rgb; ns.pf_pen = pf_pen; ns.bcol = border_rgb;
          q.push_back(ns);
          s = q.pop_front();
          m_rgb = exp_mix(s); m_hb = s.hb; m_vb = s.vb;
          if (s.cen && !s.hb && !s.vb && !s.bord && s.opq && s.pf_pen != 4'd0) hit[s.sid] = 1'b1;
        end
        nf = (coll_rd ? 8'h00 : m_flags) | hit;
        m_irq = (m_flags == 8'h00) && (nf != 8'h00);
        m_flags = nf;
        if (pal_we) m_pal[pal_addr] = pal_data;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  initial forever begin
    @(negedge clk_sys);
    if (chk_on) begin
      vectors++;
      if (rgb_out !== m_rgb || hb_out !== m_hb || vb_out !== m_vb ||
          coll_flags !== m_flags || coll_irq !== m_irq) begin
        miscompares++;
        $display("FAIL model t=%0t: got rgb=%h hb=%b vb=%b flags=%h irq=%b, expected rgb=%h hb=%b vb=%b flags=%h irq=%b",
                 $time, rgb_out, hb_out, vb_out, coll_flags, coll_irq,
                 m_rgb, m_hb, m_vb, m_flags, m_irq);
      end
    end
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic defaults();
    ce_pix = 1'b1; hblank = 1'b0; vblank = 1'b0; border = 1'b0;
    pf_rgb = 12'h123; pf_pen = 4'h0; spr_pixel = 8'h00; spr_active = 1'b0; spr_id = 4'h8;
    border_rgb = 12'hABC; prio_mask = 8'h00; coll_en = 1'b1;
    pal_we = 1'b0; pal_addr = 4'h0; pal_data = 12'h000; coll_rd = 1'b0;
  endtask

  task automatic sprite(input logic [3:0] id, input logic [7:0] pix, input logic [3:0] pen);
    spr_active = 1'b1; spr_id = id; spr_pixel = pix; pf_pen = pen;
  endtask

  task automatic clear_flags();
    coll_rd = 1'b1; tick(); coll_rd = 1'b0;
  endtask

  initial begin
    defaults();
    reset = 1'b1;
    tick(); chk_on = 1;
    tick();
    check("reset_rgb", rgb_out, 12'h000);
    check("reset_hb", {11'h0, hb_out}, 12'h001);
    check("reset_vb", {11'h0, vb_out}, 12'h001);
    check("reset_flags", {4'h0, coll_flags}, 12'h000);
    check("reset_irq", {11'h0, coll_irq}, 12'h000);
    reset = 1'b0;
    tick(); tick(); tick();
    check("idle_pf", rgb_out, 12'h123);

    // Palette write then a sprite pixel over background, two pulses of latency
    pal_we = 1'b1; pal_addr = 4'h5; pal_data = 12'hF00; tick(); pal_we = 1'b0;
    sprite(4'h2, 8'h05, 4'h0); tick(); defaults();
    check("lat_pulse1", rgb_out, 12'h123);
    tick();
    check("lat_pulse2", rgb_out, 12'hF00);

    // Sprite behind a non-zero pen still collides
    prio_mask = 8'h04; pf_rgb = 12'h0F0; sprite(4'h2, 8'h05, 4'h3); tick(); defaults(); tick();
    check("prio_behind_rgb", rgb_out, 12'h0F0);
    check("prio_behind_flags", {4'h0, coll_flags}, 12'h004);
    check("prio_behind_irq", {11'h0, coll_irq}, 12'h001);
    tick();
    check("irq_one_cycle", {11'h0, coll_irq}, 12'h000);
    clear_flags();
    check("rd_clear", {4'h0, coll_flags}, 12'h000);
    pf_rgb = 12'h0F0; sprite(4'h2, 8'h05, 4'h3); tick(); defaults(); tick();
    check("prio_front_rgb", rgb_out, 12'hF00);
    clear_flags();

    // Blanking and border
    vblank = 1'b1; sprite(4'h2, 8'h05, 4'h1); tick(); defaults(); tick();
    check("vblank_rgb", rgb_out, 12'h000);
    check("vblank_flags", {4'h0, coll_flags}, 12'h000);
    border = 1'b1; sprite(4'h2, 8'h05, 4'h1); tick(); defaults(); tick();
    check("border_rgb", rgb_out, 12'hABC);
    check("border_flags", {4'h0, coll_flags}, 12'h000);

    // IRQ only on the empty-to-non-empty transition
    sprite(4'h0, 8'h05, 4'h1); tick(); defaults(); tick();
    check("hit0_flags", {4'h0, coll_flags}, 12'h001);
    check("hit0_irq", {11'h0, coll_irq}, 12'h001);
    tick();
    sprite(4'h1, 8'h05, 4'h1); tick(); defaults(); tick();
    check("hit1_flags", {4'h0, coll_flags}, 12'h003);
    check("hit1_irq", {11'h0, coll_irq}, 12'h000);
    clear_flags();
    sprite(4'h0, 8'h05, 4'h1); tick(); defaults(); tick(); tick();
    check("race_pre", {4'h0, coll_flags}, 12'h001);
    // Read-clear on the same edge as a new hit on sprite 6
    sprite(4'h6, 8'h05, 4'h1); tick(); defaults(); coll_rd = 1'b1; tick(); coll_rd = 1'b0;
    check("race_flags", {4'h0, coll_flags}, 12'h040);
    check("race_irq", {11'h0, coll_irq}, 12'h000);
    clear_flags();

    // Outputs hold while ce_pix is low; write bypass into stage 1
    ce_pix = 1'b0; pf_rgb = 12'h456; tick(); tick();
    check("hold_rgb", rgb_out, 12'h123);
    ce_pix = 1'b1; pf_rgb = 12'h123;
    pal_we = 1'b1; pal_addr = 4'h7; pal_data = 12'h0AB; sprite(4'hB, 8'h07, 4'h0);
    check("hb_active", {11'h0, hb_out}, 12'h000);
    tick(); defaults(); ce_pix = 1'b0; spr_id = 4'h3; spr_active = 1'b1; spr_pixel = 8'h07; tick(); tick();
    check("hold2_rgb", rgb_out, 12'h123);
    defaults(); tick();
    check("bypass_rgb", rgb_out, 12'h123);
    pal_we = 1'b1; pal_addr = 4'h9; pal_data = 12'h5A5; sprite(4'h3, 8'h09, 4'h0); tick();
    defaults(); tick();
    check("bypass2_rgb", rgb_out, 12'h5A5);

    // Reset mid-line
    pf_rgb = 12'h3C3; sprite(4'h4, 8'h05, 4'h2); tick(); tick(); tick();
    check("stream_rgb", rgb_out, 12'hF00);
    reset = 1'b1; tick(); reset = 1'b0; spr_active = 1'b0;
    check("rst_mid_hb", {11'h0, hb_out}, 12'h001);
    check("rst_mid_rgb", rgb_out, 12'h000);
    tick();
    check("rst_p1_vb", {11'h0, vb_out}, 12'h001);
    check("rst_p1_rgb", rgb_out, 12'h000);
    tick();
    check("rst_p2_hb", {11'h0, hb_out}, 12'h000);
    check("rst_p2_rgb", rgb_out, 12'h3C3);

    // Mixed traffic checked by the model alone
    for (int n = 0; n < 400; n++) begin
      ce_pix     = ($urandom_range(0, 3) != 0);
      hblank     = ($urandom_range(0, 9) == 0);
      vblank     = ($urandom_range(0, 15) == 0);
      border     = ($urandom_range(0, 7) == 0);
      pf_rgb     = 12'($urandom);
      pf_pen     = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      spr_pixel  = 8'($urandom);
      spr_active = ($urandom_range(0, 3) != 0);
      spr_id     = 4'($urandom);
      border_rgb = 12'($urandom);
      prio_mask  = 8'($urandom);
      coll_en    = ($urandom_range(0, 7) != 0);
      pal_we     = ($urandom_range(0, 3) == 0);
      pal_addr   = 4'($urandom);
      pal_data   = 12'($urandom);
      coll_rd    = ($urandom_range(0, 11) == 0);
      reset      = ($urandom_range(0, 199) == 0);
      tick();
    end
    defaults(); reset = 1'b0; tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
